// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter with a valid/ready handshake on both sides.
//
// Supports rotate, logical shift and arithmetic shift, left or right, at any power-of-two WIDTH.
// There is one register stage per shift-amount bit. Stage k applies a shift of 2^k positions
// when bit k of the shift amount is set, and otherwise passes the data through. The latency is
// SHW cycles, and the block sustains one result per cycle while the consumer is ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; discards everything in flight
//   in_valid   producer presents an operation
//   in_ready   an operation can be accepted this cycle (independent of in_valid)
//   in_data    operand
//   in_shamt   shift amount, 0..WIDTH-1
//   in_left    1 = shift/rotate left, 0 = right
//   in_mode    00 rotate, 01 logical, 10 arithmetic, 11 rotate
//   out_valid  result available
//   out_ready  consumer accepts the result
//   out_data   shifted result, held stable while stalled
module barrel_shifter_pipe #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_left,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam logic [WIDTH-1:0] Ones = {WIDTH{1'b1}};

    // One 2^k step. 's' is always a power of two below WIDTH, so WIDTH - s is never zero.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input int unsigned      s,
        input logic             left,
        input logic [1:0]       mode,
        input logic             sign
    );
        logic [WIDTH-1:0] r;
        case (mode)
            2'b01: r = left ? (d << s) : (d >> s);
            // Arithmetic left is the same as logical left.
            2'b10: r = left ? (d << s) : ((d >> s) | (sign ? ~(Ones >> s) : '0));
            // 00 and the reserved 11 both rotate.
            default: r = left ? ((d << s) | (d >> (WIDTH - s)))
                              : ((d >> s) | (d << (WIDTH - s)));
        endcase
        return r;
    endfunction

    // Stage registers
    logic [SHW-1:0]   valid_q;
    logic [WIDTH-1:0] data_q  [SHW];
    logic [SHW-1:0]   shamt_q [SHW];
    logic             left_q  [SHW];
    logic [1:0]       mode_q  [SHW];
    logic             sign_q  [SHW];

    // Inputs seen by each stage: stage 0 takes the ports, stage k takes stage k-1
    logic [SHW-1:0]   src_valid;
    logic [WIDTH-1:0] src_data  [SHW];
    logic [SHW-1:0]   src_shamt [SHW];
    logic             src_left  [SHW];
    logic [1:0]       src_mode  [SHW];
    logic             src_sign  [SHW];
    logic [WIDTH-1:0] data_d    [SHW];

    logic [SHW-1:0]   load;

    // Stage k loads when it or any stage after it is empty, or when the consumer pops.
    // This is the unrolled form of "empty, or the next stage loads", so bubbles collapse.
    for (genvar k = 0; k < SHW; k++) begin : g_load
        assign load[k] = out_ready | ~(&valid_q[SHW-1:k]);
    end

    assign in_ready  = load[0];
    assign out_valid = valid_q[SHW-1];
    assign out_data  = data_q[SHW-1];

    always_comb begin
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        src_shamt[0] = in_shamt;
        src_left[0]  = in_left;
        src_mode[0]  = in_mode;
        // The sign comes from the original operand and travels with the operation.
        src_sign[0]  = in_data[WIDTH-1];
        for (int k = 1; k < SHW; k++) begin
            src_valid[k] = valid_q[k-1];
            src_data[k]  = data_q[k-1];
            src_shamt[k] = shamt_q[k-1];
            src_left[k]  = left_q[k-1];
            src_mode[k]  = mode_q[k-1];
            src_sign[k]  = sign_q[k-1];
        end
        for (int k = 0; k < SHW; k++) begin
            data_d[k] = src_shamt[k][k]
                      ? shift_step(src_data[k], 32'd1 << k, src_left[k], src_mode[k], src_sign[k])
                      : src_data[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < SHW; k++) begin
                data_q[k]  <= '0;
                shamt_q[k] <= '0;
                left_q[k]  <= 1'b0;
                mode_q[k]  <= 2'b00;
                sign_q[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < SHW; k++) begin
                if (load[k]) begin
                    valid_q[k] <= src_valid[k];
                    // A bubble moving in leaves the payload untouched.
                    if (src_valid[k]) begin
                        data_q[k]  <= data_d[k];
                        shamt_q[k] <= src_shamt[k];
                        left_q[k]  <= src_left[k];
                        mode_q[k]  <= src_mode[k];
                        sign_q[k]  <= src_sign[k];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Testbench for barrel_shifter_pipe: WIDTH=8 and WIDTH=32 instances, directed vectors,
// queue scoreboard filled on input acceptance and drained by an output monitor.
module tb_barrel_shifter_pipe;

    typedef struct {
        logic [31:0] data;
        bit          lat;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic [2:0] sh;
        logic       l;
        logic [1:0] m;
        logic [7:0] e;
    } vec8_t;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  sh;
        logic        l;
        logic [1:0]  m;
        logic [31:0] e;
    } vec32_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    // WIDTH=8 instance signals
    logic       iv8, ir8, ov8, or8, l8;
    logic [7:0] id8, od8;
    logic [2:0] sh8;
    logic [1:0] m8;
    logic [7:0] exp8;
    bit         lat8;
    exp_t       sb8[$];

    // WIDTH=32 instance signals
    logic        iv32, ir32, ov32, or32, l32;
    logic [31:0] id32, od32;
    logic [4:0]  sh32;
    logic [1:0]  m32;
    logic [31:0] exp32;
    exp_t        sb32[$];

    vec8_t  vecs8  [18];
    vec32_t vecs32 [5];

    barrel_shifter_pipe #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .in_data   (id8),
        .in_shamt  (sh8),
        .in_left   (l8),
        .in_mode   (m8),
        .out_valid (ov8),
        .out_ready (or8),
        .out_data  (od8)
    );

    barrel_shifter_pipe #(.WIDTH(32)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv32),
        .in_ready  (ir32),
        .in_data   (id32),
        .in_shamt  (sh32),
        .in_left   (l32),
        .in_mode   (m32),
        .out_valid (ov32),
        .out_ready (or32),
        .out_data  (od32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic ok, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitors: outputs are checked against the queue front; accepted inputs are queued.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov8) begin
                check("out8_has_pending", sb8.size() != 0, od8, 32'd0);
                if (sb8.size() != 0) begin
                    check("out8_data", od8 === sb8[0].data[7:0], od8, sb8[0].data);
                    if (or8) begin
                        if (sb8[0].lat)
                            check("out8_latency", cyc - sb8[0].cyc == 3, cyc - sb8[0].cyc, 3);
                        void'(sb8.pop_front());
                    end
                end
            end
            if (iv8 && ir8) sb8.push_back('{{24'd0, exp8}, lat8, cyc});
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (ov32) begin
                check("out32_has_pending", sb32.size() != 0, od32, 32'd0);
                if (sb32.size() != 0) begin
                    check("out32_data", od32 === sb32[0].data, od32, sb32[0].data);
                    if (or32) begin
                        check("out32_latency", cyc - sb32[0].cyc == 5, cyc - sb32[0].cyc, 5);
                        void'(sb32.pop_front());
                    end
                end
            end
            if (iv32 && ir32) sb32.push_back('{exp32, 1'b1, cyc});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one operation and hold it until accepted (bounded).
    task automatic send8(input logic [7:0] d, input logic [2:0] sh, input logic l,
                         input logic [1:0] m, input logic [7:0] e, input bit lat);
        int n;
        n    = 0;
        iv8  = 1'b1;
        id8  = d;
        sh8  = sh;
        l8   = l;
        m8   = m;
        exp8 = e;
        lat8 = lat;
        @(negedge clk);
        while (!ir8 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("send8_accepted", ir8, ir8, 1);
        @(posedge clk);
        #1;
        iv8 = 1'b0;
    endtask

    task automatic send32(input logic [31:0] d, input logic [4:0] sh, input logic l,
                          input logic [1:0] m, input logic [31:0] e);
        int n;
        n     = 0;
        iv32  = 1'b1;
        id32  = d;
        sh32  = sh;
        l32   = l;
        m32   = m;
        exp32 = e;
        @(negedge clk);
        while (!ir32 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("send32_accepted", ir32, ir32, 1);
        @(posedge clk);
        #1;
        iv32 = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb8.size() != 0 || sb32.size() != 0) && n < 200) begin
            n++;
            @(posedge clk);
        end
        #1;
        check(name, sb8.size() == 0 && sb32.size() == 0, sb8.size() + sb32.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs8 = '{
            '{8'hB3, 3'd3, 1'b0, 2'b00, 8'h76},
            '{8'hB3, 3'd3, 1'b1, 2'b00, 8'h9D},
            '{8'hB3, 3'd3, 1'b0, 2'b01, 8'h16},
            '{8'hB3, 3'd3, 1'b0, 2'b10, 8'hF6},
            '{8'hCC, 3'd2, 1'b1, 2'b01, 8'h30},
            '{8'hCC, 3'd2, 1'b0, 2'b00, 8'h33},
            '{8'hA5, 3'd0, 1'b0, 2'b00, 8'hA5},
            '{8'hA5, 3'd0, 1'b1, 2'b01, 8'hA5},
            '{8'hA5, 3'd0, 1'b0, 2'b10, 8'hA5},
            '{8'hA5, 3'd0, 1'b1, 2'b11, 8'hA5},
            '{8'hB3, 3'd3, 1'b1, 2'b10, 8'h98},
            '{8'hB3, 3'd3, 1'b1, 2'b11, 8'h9D},
            '{8'h81, 3'd7, 1'b0, 2'b00, 8'h03},
            '{8'hB3, 3'd7, 1'b0, 2'b01, 8'h01},
            '{8'hB3, 3'd7, 1'b0, 2'b10, 8'hFF},
            '{8'h73, 3'd2, 1'b0, 2'b10, 8'h1C},
            '{8'hB3, 3'd5, 1'b1, 2'b01, 8'h60},
            '{8'h80, 3'd6, 1'b0, 2'b10, 8'hFE}
        };
        vecs32 = '{
            '{32'h8000_0001, 5'd31, 1'b0, 2'b10, 32'hFFFF_FFFF},
            '{32'h8000_0001, 5'd4,  1'b1, 2'b00, 32'h0000_0018},
            '{32'h1234_5678, 5'd16, 1'b0, 2'b01, 32'h0000_1234},
            '{32'h8000_0001, 5'd31, 1'b0, 2'b01, 32'h0000_0001},
            '{32'h8000_0001, 5'd0,  1'b0, 2'b10, 32'h8000_0001}
        };
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        iv8 = 1'b0; id8 = '0; sh8 = '0; l8 = 1'b0; m8 = '0; or8 = 1'b1; exp8 = '0; lat8 = 1'b0;
        iv32 = 1'b0; id32 = '0; sh32 = '0; l32 = 1'b0; m32 = '0; or32 = 1'b1; exp32 = '0;
        #1;
        check("reset_out_valid", ov8 == 1'b0, ov8, 0);
        check("reset_out_data", od8 == 8'h00, od8, 0);
        check("reset_in_ready", ir8 == 1'b1, ir8, 1);
        step(2);
        rst_n = 1'b1;
        step(1);

        // Directed vectors, back-to-back with out_ready high: latency 3, one per cycle.
        foreach (vecs8[i])
            send8(vecs8[i].d, vecs8[i].sh, vecs8[i].l, vecs8[i].m, vecs8[i].e, 1'b1);
        drain("drain_vectors");

        // Fill with the consumer stalled, then pop and push in the same cycle.
        or8 = 1'b0;
        send8(8'hA5, 3'd1, 1'b1, 2'b01, 8'h4A, 1'b0);
        send8(8'h0F, 3'd4, 1'b0, 2'b00, 8'hF0, 1'b0);
        send8(8'h81, 3'd1, 1'b0, 2'b10, 8'hC0, 1'b0);
        iv8 = 1'b1; id8 = 8'h3C; sh8 = 3'd1; l8 = 1'b1; m8 = 2'b00; exp8 = 8'h78; lat8 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("full_in_ready", ir8 == 1'b0, ir8, 0);
            check("full_out_hold", od8 == 8'h4A, od8, 8'h4A);
        end
        @(posedge clk);
        #1;
        or8 = 1'b1;
        @(negedge clk);
        check("pop_push_in_ready", ir8 == 1'b1, ir8, 1);
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        drain("drain_stall");

        // Reset with two operations in flight, one already at the output.
        or8 = 1'b0;
        send8(8'h0F, 3'd4, 1'b0, 2'b00, 8'hF0, 1'b0);
        send8(8'hB3, 3'd3, 1'b0, 2'b00, 8'h76, 1'b0);
        step(1);
        check("pre_reset_out_valid", ov8 == 1'b1, ov8, 1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_out_valid", ov8 == 1'b0, ov8, 0);
        check("mid_reset_out_data", od8 == 8'h00, od8, 0);
        check("mid_reset_in_ready", ir8 == 1'b1, ir8, 1);
        sb8.delete();
        step(2);
        rst_n = 1'b1;
        or8 = 1'b1;
        step(6);
        send8(8'hB3, 3'd3, 1'b1, 2'b00, 8'h9D, 1'b1);
        drain("drain_after_reset");

        // WIDTH=32 instance: latency 5.
        foreach (vecs32[i])
            send32(vecs32[i].d, vecs32[i].sh, vecs32[i].l, vecs32[i].m, vecs32[i].e);
        drain("drain_w32");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
- Parametrised, pipelined successor to the team's 8-bit combinational rotator.
- Supports rotate, logical shift and arithmetic shift in both directions, at any power-of-two WIDTH.
- Uses one register stage per shift-amount bit, with a valid/ready handshake on input and output.
- Sits between a producer and a consumer datapath and sustains one result per clock when not back-pressured.

Parameters:
- WIDTH, 8, data width in bits; must be a power of two, ≥ 2.
- SHW, $clog2(WIDTH), shift-amount width and pipeline depth; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer presents an operation
- in_ready  output  1  block can accept the operation this cycle
- in_data  input  WIDTH  operand
- in_shamt  input  SHW  shift amount, 0..WIDTH-1
- in_left  input  1  1 = left, 0 = right (same sense as the existing left_rot)
- in_mode  input  2  00 rotate, 01 logical, 10 arithmetic, 11 reserved (treated as rotate)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  shifted result

Behaviour:
- Reset (asynchronous, rst_n low):
  - All stage valid bits clear and all stage data registers clear, immediately.
  - out_valid=0, out_data=0, in_ready=1 once any stage is free. Since all stages are free after reset, in_ready=1.
- Transfers:
  - Input transfer on in_valid & in_ready at the rising clk edge.
  - Output transfer on out_valid & out_ready at the rising clk edge.
- Pipeline:
  - Stages 0..SHW-1. Stage k applies a shift of 2^k positions when shamt bit k is 1, otherwise passes the data through.
  - Each stage carries forward: data, remaining shamt, left, mode, and a valid bit.
- Latency:
  - An accepted operation reaches out_valid exactly SHW cycles later, provided no stall occurs.
  - Example: WIDTH=8 gives a latency of 3 cycles.
- Throughput: one operation per cycle when out_ready is held high.
- Back-pressure (bubble-collapsing):
  - Stage k loads when it is empty, or when stage k+1 loads in the same cycle. The last stage's downstream condition is out_ready.
  - in_ready = stage-0 load condition, purely combinational from stage valids and out_ready. It must not depend on in_valid.
  - While out_valid=1 and out_ready=0, out_data is held stable.
  - No operation is dropped or duplicated. Up to SHW operations may be in flight.
- Mode rules, per 2^k step:
  - Rotate: bits shifted out re-enter at the opposite end.
  - Logical: vacated bits are filled with 0.
  - Arithmetic right: vacated bits are filled with the MSB of the original operand, carried as a sign bit with the operation.
  - Arithmetic left: identical to logical left.
  - Mode 11: behaves exactly as rotate.
- Boundary cases:
  - shamt=0: out_data equals in_data in every mode, with the same latency.
  - The shift amount never reaches WIDTH; the full SHW-bit range is legal.
  - A pipeline that is full with out_ready=0 gives in_ready=0. A simultaneous output pop and input push is allowed in the same cycle.
  - Reset asserted mid-operation: all in-flight operations are discarded and no out_valid follows the deassertion of reset.
- Ordering: results leave strictly in acceptance order.

Test Plan:
- WIDTH=8, in_data=8'b10110011, shamt=3, left=0, mode=00 → out_data=8'b01110110, 3 cycles after accept.
- Same operand and shamt with left=1, mode=00 → 8'b10011101. With left=0, mode=01 → 8'b00010110. With left=0, mode=10 → 8'b11110110.
- Back-to-back stream with out_ready held high: 8'b11001100, shamt=2, left=1, mode=01 → 8'b00110000, followed by the same operand with left=0, mode=00 → 8'b00110011. Results appear on consecutive cycles.
- Push 4 operations with out_ready=0:
  - After 3 accepts in_ready=0, and out_data holds the first result stable.
  - Raise out_ready: all 3 results drain in order, the 4th is accepted on the first pop cycle, and none are lost.
- shamt=0 in all four modes with in_data=8'hA5 → out_data=8'hA5. Repeat at WIDTH=32 with 32'h8000_0001, shamt=31, left=0, mode=10 → 32'hFFFF_FFFF.
- Assert rst_n low while 2 operations are in flight → out_valid=0 immediately, and no spurious output after release. The next operation completes normally with 3-cycle latency.
